// File: rtl/dmi_pkg.sv
// dmi_pkg: shared constants and types for the DMI arbiter.
//   - default DMI field widths
//   - op encodings (NOP/READ/WRITE) and response encodings (OK/FAIL/BUSY)
//   - arbiter FSM state type
package dmi_pkg;

    localparam int DMI_DATA_BITS = 34;
    localparam int DMI_ADDR_BITS = 5;
    localparam int DMI_OP_BITS   = 2;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_RESP_OK   = 2'd0;
    localparam logic [1:0] DMI_RESP_FAIL = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dmi_state_e;

endpackage

// File: rtl/dmi_rr_picker.sv
// dmi_rr_picker: two-way round-robin grant selection (purely combinational).
// Ports:
//   valid[1:0]  in   request valids from requester 1/0
//   rr          in   preferred requester when both are valid
//   advance     in   grants are allowed this cycle
//   grant[1:0]  out  one-hot grant, all-zero when advance is low
module dmi_rr_picker (
    input  logic [1:0] valid,
    input  logic       rr,
    input  logic       advance,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (advance) begin
            if (valid == 2'b11) begin
                grant = rr ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares one debug-module DMI port between two requesters,
// one transaction outstanding at a time, round-robin between requesters.
// Optional feature macro: DMI_ARB_TIMEOUT_EN -- response timeout with a
// stale-response drain; when undefined, WAIT persists until the DM answers.
// Ports:
//   clock, reset                 sole clock; synchronous active-high reset
//   reqN_valid/ready/bits        requester N request, bits = {addr, data, op}
//   rspN_valid/ready/bits        requester N response, bits = {data, resp}
//   dm_req_valid/ready/bits      forwarded request to the debug module
//   dm_resp_valid/ready/bits     response from the debug module
//
// state | meaning
// IDLE  | no transaction; grant a requester (unless a stale response is pending)
// ISSUE | present registered request to the DM until accepted
// WAIT  | wait for the DM response (or timeout when enabled)
// RESP  | present registered response to the owning requester
module dmi_arbiter
    import dmi_pkg::*;
#(
    parameter int DEBUG_DATA_BITS = DMI_DATA_BITS,
    parameter int DEBUG_ADDR_BITS = DMI_ADDR_BITS,
    parameter int DEBUG_OP_BITS   = DMI_OP_BITS,
    parameter int TIMEOUT_CYCLES  = 255,
    localparam int REQ_W = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS,
    localparam int RSP_W = DEBUG_OP_BITS + DEBUG_DATA_BITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [REQ_W-1:0] req0_bits,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [RSP_W-1:0] rsp0_bits,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [REQ_W-1:0] req1_bits,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [RSP_W-1:0] rsp1_bits,
    output logic             dm_req_valid,
    input  logic             dm_req_ready,
    output logic [REQ_W-1:0] dm_req_bits,
    input  logic             dm_resp_valid,
    output logic             dm_resp_ready,
    input  logic [RSP_W-1:0] dm_resp_bits
);

    localparam bit CFG_OK = (DEBUG_ADDR_BITS >= 5) && (DEBUG_ADDR_BITS <= 7)
                            && (TIMEOUT_CYCLES > 0);

    if (!CFG_OK) begin : g_bad_cfg
        $error("dmi_arbiter: DEBUG_ADDR_BITS must be 5..7 and TIMEOUT_CYCLES > 0");
    end

    dmi_state_e       state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [REQ_W-1:0] req_bits_q, req_bits_d;
    logic [RSP_W-1:0] rsp_bits_q, rsp_bits_d;
    logic             dm_req_valid_q, dm_req_valid_d;
    logic             dm_resp_ready_q, dm_resp_ready_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic             grant_en;
    logic [1:0]       grant;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stale_q, stale_d;

    // A late response to an abandoned request must be drained before the
    // next request is issued, otherwise it would be taken as that answer.
    assign grant_en = (state_q == ST_IDLE) && !reset && !stale_q;
`else
    assign grant_en = (state_q == ST_IDLE) && !reset;
`endif

    dmi_rr_picker u_picker (
        .valid   ({req1_valid, req0_valid}),
        .rr      (rr_q),
        .advance (grant_en),
        .grant   (grant)
    );

    // Ready is combinational so the grant handshake completes in the IDLE cycle.
    assign req0_ready    = grant[0];
    assign req1_ready    = grant[1];
    assign dm_req_valid  = dm_req_valid_q;
    assign dm_req_bits   = req_bits_q;
    assign dm_resp_ready = dm_resp_ready_q;
    assign rsp0_valid    = rsp0_valid_q;
    assign rsp1_valid    = rsp1_valid_q;
    assign rsp0_bits     = rsp_bits_q;
    assign rsp1_bits     = rsp_bits_q;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        req_bits_d = req_bits_q;
        rsp_bits_d = rsp_bits_q;
`ifdef DMI_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        stale_d    = stale_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    owner_d    = grant[1];
                    req_bits_d = grant[1] ? req1_bits : req0_bits;
                    rr_d       = ~grant[1];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dm_req_valid_q && dm_req_ready) begin
                    state_d = ST_WAIT;
`ifdef DMI_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (dm_resp_valid && dm_resp_ready_q) begin
                    rsp_bits_d = dm_resp_bits;
                    state_d    = ST_RESP;
                end
`ifdef DMI_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rsp_bits_d = {{DEBUG_DATA_BITS{1'b0}}, DEBUG_OP_BITS'(DMI_RESP_FAIL)};
                    state_d    = ST_RESP;
                    stale_d    = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef DMI_ARB_TIMEOUT_EN
        // Stale is never set in WAIT, so this does not collide with the timeout above.
        if (stale_q) begin
            if (dm_resp_valid && dm_resp_ready_q) begin
                stale_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                stale_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        dm_resp_ready_d = (state_d == ST_WAIT) || stale_d;
`else
        dm_resp_ready_d = (state_d == ST_WAIT);
`endif
        dm_req_valid_d = (state_d == ST_ISSUE);
        rsp0_valid_d   = (state_d == ST_RESP) && !owner_d;
        rsp1_valid_d   = (state_d == ST_RESP) && owner_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rr_q            <= 1'b0;
            owner_q         <= 1'b0;
            req_bits_q      <= '0;
            rsp_bits_q      <= '0;
            dm_req_valid_q  <= 1'b0;
            dm_resp_ready_q <= 1'b0;
            rsp0_valid_q    <= 1'b0;
            rsp1_valid_q    <= 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
            cnt_q           <= '0;
            stale_q         <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            rr_q            <= rr_d;
            owner_q         <= owner_d;
            req_bits_q      <= req_bits_d;
            rsp_bits_q      <= rsp_bits_d;
            dm_req_valid_q  <= dm_req_valid_d;
            dm_resp_ready_q <= dm_resp_ready_d;
            rsp0_valid_q    <= rsp0_valid_d;
            rsp1_valid_q    <= rsp1_valid_d;
`ifdef DMI_ARB_TIMEOUT_EN
            cnt_q           <= cnt_d;
            stale_q         <= stale_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter: self-checking bench for dmi_arbiter.
// Directed scenarios plus randomized transactions checked against a
// transaction-level model (round-robin pointer, owner bits, DM echo).
module tb_dmi_arbiter;
    import dmi_pkg::*;

    localparam int DW    = 34;
    localparam int AW    = 5;
    localparam int OW    = 2;
    localparam int REQ_W = OW + AW + DW;
    localparam int RSP_W = OW + DW;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [REQ_W-1:0] req0_bits = '0, req1_bits = '0;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [RSP_W-1:0] rsp0_bits, rsp1_bits;
    logic             dm_req_valid;
    logic             dm_req_ready = 1'b0;
    logic [REQ_W-1:0] dm_req_bits;
    logic             dm_resp_valid = 1'b0;
    logic             dm_resp_ready;
    logic [RSP_W-1:0] dm_resp_bits = '0;

    int checks   = 0;
    int failures = 0;
    int rr_m     = 0;

    always #5 clock = ~clock;

    dmi_arbiter #(
        .DEBUG_DATA_BITS (DW),
        .DEBUG_ADDR_BITS (AW),
        .DEBUG_OP_BITS   (OW),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_bits     (req0_bits),
        .rsp0_valid    (rsp0_valid),
        .rsp0_ready    (rsp0_ready),
        .rsp0_bits     (rsp0_bits),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_bits     (req1_bits),
        .rsp1_valid    (rsp1_valid),
        .rsp1_ready    (rsp1_ready),
        .rsp1_bits     (rsp1_bits),
        .dm_req_valid  (dm_req_valid),
        .dm_req_ready  (dm_req_ready),
        .dm_req_bits   (dm_req_bits),
        .dm_resp_valid (dm_resp_valid),
        .dm_resp_ready (dm_resp_ready),
        .dm_resp_bits  (dm_resp_bits)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input logic [AW-1:0] a,
                                                input logic [DW-1:0] d,
                                                input logic [OW-1:0] op);
        return {a, d, op};
    endfunction

    // One full transaction: grant, DM request, DM response, requester response.
    task automatic txn(input bit v0, input bit v1,
                       input logic [REQ_W-1:0] b0, input logic [REQ_W-1:0] b1,
                       input int req_wait, input int resp_wait, input int rsp_wait,
                       input logic [RSP_W-1:0] dm_rsp);
        int               own;
        logic [REQ_W-1:0] exp_bits;
        req0_valid = v0;
        req1_valid = v1;
        req0_bits  = b0;
        req1_bits  = b1;
        #1;
        own = (v0 && v1) ? rr_m : (v1 ? 1 : 0);
        chk("grant_req0_ready", req0_ready, own == 0);
        chk("grant_req1_ready", req1_ready, own == 1);
        rr_m     = 1 - own;
        exp_bits = own ? b1 : b0;
        step();
        if (own == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        for (int k = 0; k < req_wait; k++) begin
            chk("issue_valid_hold", dm_req_valid, 1);
            chk("issue_bits_hold", dm_req_bits, exp_bits);
            chk("issue_no_ready", {req1_ready, req0_ready}, 0);
            step();
        end
        chk("issue_valid", dm_req_valid, 1);
        chk("issue_bits", dm_req_bits, exp_bits);
        chk("issue_resp_ready", dm_resp_ready, 0);
        dm_req_ready = 1'b1;
        step();
        dm_req_ready = 1'b0;
        chk("wait_no_dm_req", dm_req_valid, 0);
        for (int k = 0; k <= resp_wait; k++) begin
            chk("wait_resp_ready", dm_resp_ready, 1);
            chk("wait_no_rsp", {rsp1_valid, rsp0_valid}, 0);
            chk("wait_no_ready", {req1_ready, req0_ready}, 0);
            if (k == resp_wait) begin
                dm_resp_valid = 1'b1;
                dm_resp_bits  = dm_rsp;
            end
            step();
        end
        dm_resp_valid = 1'b0;
        dm_resp_bits  = '0;
        for (int k = 0; k <= rsp_wait; k++) begin
            chk("rsp_owner_valid", own ? rsp1_valid : rsp0_valid, 1);
            chk("rsp_other_valid", own ? rsp0_valid : rsp1_valid, 0);
            chk("rsp_bits", own ? rsp1_bits : rsp0_bits, dm_rsp);
            chk("rsp_no_ready", {req1_ready, req0_ready}, 0);
            chk("rsp_no_dm_req", dm_req_valid, 0);
            chk("rsp_dm_resp_ready", dm_resp_ready, 0);
            if (k == rsp_wait) begin
                if (own == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            end
            step();
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk("done_rsp_cleared", {rsp1_valid, rsp0_valid}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]      r64;
        logic [REQ_W-1:0] rb0, rb1;
        logic [RSP_W-1:0] rr_rsp;
        int               pat;

        // Reset: everything quiet even with requests pending.
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        chk("rst_req_ready", {req1_ready, req0_ready}, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_dm_req_valid", dm_req_valid, 0);
        chk("rst_dm_resp_ready", dm_resp_ready, 0);
        chk("rst_dm_req_bits", dm_req_bits, 0);
        chk("rst_rsp_bits", {rsp1_bits, rsp0_bits}, 0);
        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rr_m       = 0;
        step();
        chk("idle_quiet", {dm_req_valid, rsp1_valid, rsp0_valid}, 0);

        // Both requesters continuously valid: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            chk("alt_expected_owner", rr_m, i % 2);
            txn(1, 1, mk_req(5'(i), 34'(i * 3 + 1), DMI_OP_WRITE),
                mk_req(5'(i + 8), 34'(i * 5 + 2), DMI_OP_READ), 0, 0, 0,
                {34'(100 + i), DMI_RESP_OK});
        end

        // Single requester read, DM answers two cycles into WAIT.
        txn(1, 0, mk_req(5'h10, 34'h0, DMI_OP_READ), '0, 0, 2, 0,
            {34'h1234, DMI_RESP_OK});

        // Requester 1 owns, holds off its response for 5 cycles.
        txn(1, 1, mk_req(5'h01, 34'h2_AAAA_5555, DMI_OP_WRITE),
            mk_req(5'h02, 34'h1_0F0F_F0F0, DMI_OP_READ), 0, 0, 5,
            {34'h3_DEAD_BEEF, DMI_RESP_BUSY});

        // DM back-pressures the request for 10 cycles.
        txn(1, 1, mk_req(5'h11, 34'h0_1357_9BDF, DMI_OP_READ),
            mk_req(5'h12, 34'h2_468A_CE02, DMI_OP_WRITE), 10, 0, 0,
            {34'h0_CAFE_F00D, DMI_RESP_OK});

`ifdef DMI_ARB_TIMEOUT_EN
        // Silent DM: fail response after 8 WAIT cycles, then drain the late beat.
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_bits  = mk_req(5'h05, 34'h5, DMI_OP_READ);
        #1;
        chk("to_grant", req0_ready, 1);
        rr_m = 1;
        step();
        req0_valid   = 1'b0;
        dm_req_ready = 1'b1;
        step();
        dm_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("to_wait_no_rsp", rsp0_valid, 0);
            chk("to_wait_resp_ready", dm_resp_ready, 1);
            step();
        end
        chk("to_rsp_valid", rsp0_valid, 1);
        chk("to_rsp_bits", rsp0_bits, {34'h0, 2'b10});
        chk("to_stale_resp_ready", dm_resp_ready, 1);
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1;
        #1;
        chk("stale_no_grant", req0_ready, 0);
        chk("stale_resp_ready", dm_resp_ready, 1);
        step();
        chk("stale_no_grant2", req0_ready, 0);
        dm_resp_valid = 1'b1;
        dm_resp_bits  = {34'h3_FFFF_0000, DMI_RESP_OK};
        step();
        dm_resp_valid = 1'b0;
        dm_resp_bits  = '0;
        chk("drained_resp_ready", dm_resp_ready, 0);
        chk("drained_no_rsp", rsp0_valid, 0);
        txn(1, 0, mk_req(5'h06, 34'h6, DMI_OP_WRITE), '0, 0, 0, 0,
            {34'h66, DMI_RESP_OK});
`endif

        // Randomized transactions.
        for (int i = 0; i < 30; i++) begin
            pat = $urandom_range(1, 3);
            r64 = {$urandom, $urandom};
            rb0 = r64[REQ_W-1:0];
            r64 = {$urandom, $urandom};
            rb1 = r64[REQ_W-1:0];
            r64 = {$urandom, $urandom};
            rr_rsp = r64[RSP_W-1:0];
            txn(pat[0], pat[1], rb0, rb1, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), rr_rsp);
        end

        // Reset while waiting for the DM: transaction abandoned, rr back to 0.
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_bits  = mk_req(5'h1F, 34'h1_1111_1111, DMI_OP_READ);
        #1;
        chk("rw_grant", req1_ready, 1);
        step();
        req1_valid   = 1'b0;
        dm_req_ready = 1'b1;
        step();
        dm_req_ready = 1'b0;
        chk("rw_in_wait", dm_resp_ready, 1);
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        chk("rw_rst_valids", {rsp1_valid, rsp0_valid, dm_req_valid}, 0);
        chk("rw_rst_readies", {dm_resp_ready, req1_ready, req0_ready}, 0);
        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rr_m       = 0;
        step();
        chk("rw_after_no_rsp", {rsp1_valid, rsp0_valid}, 0);
        chk("rw_after_idle", {dm_req_valid, dm_resp_ready}, 0);
        txn(1, 1, mk_req(5'h03, 34'h3, DMI_OP_READ), mk_req(5'h04, 34'h4, DMI_OP_READ),
            0, 0, 0, {34'h0_0000_0ABC, DMI_RESP_OK});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmi_arbiter.md
DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 The block SHALL have parameter DEBUG_DATA_BITS, default 34, the DMI data width.
REQ-002 The block SHALL have parameter DEBUG_ADDR_BITS, default 5, the DMI address width (legal 5-7).
REQ-003 The block SHALL have parameter DEBUG_OP_BITS, default 2, the op/resp width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the response wait limit (used only with DMI_ARB_TIMEOUT_EN).
REQ-005 The block SHALL have these ports; REQ = OP+ADDR+DATA bits, RSP = OP+DATA bits:
clock  in  1  sole clock, all logic on posedge
reset  in  1  synchronous, active-high
req0_valid/req0_ready  in/out  1/1  requester 0 request handshake
req0_bits  in  REQ  {addr, data, op}, op in LSBs
rsp0_valid/rsp0_ready  out/in  1/1  requester 0 response handshake
rsp0_bits  out  RSP  {data, resp}, resp in LSBs
req1_*/rsp1_*  same as requester 0, for requester 1
dm_req_valid/dm_req_ready  out/in  1/1  debug-module request handshake
dm_req_bits  out  REQ  forwarded request
dm_resp_valid/dm_resp_ready  in/out  1/1  debug-module response handshake
dm_resp_bits  in  RSP  debug-module response

Function
REQ-006 The block SHALL share one DM port between two requesters, with at most one transaction outstanding.
REQ-007 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-008 In IDLE with any reqN_valid, the block SHALL grant one requester, assert its reqN_ready that cycle, register bits and owner, and go to ISSUE.
REQ-009 Grant SHALL be round-robin: with both requesters valid, the rr pointer wins; after a grant to N, rr SHALL point to the other requester.
REQ-010 reqN_ready SHALL be 0 in all states other than IDLE.
REQ-011 In ISSUE, dm_req_valid SHALL be 1 with stable registered bits; dm_req_valid && dm_req_ready SHALL move the FSM to WAIT.
REQ-012 In WAIT, dm_resp_ready SHALL be 1; dm_resp_valid SHALL register dm_resp_bits and move the FSM to RESP.
REQ-013 In RESP, only the owner's rspN_valid SHALL be 1, with the registered bits; rspN_ready SHALL return the FSM to IDLE.
REQ-014 Minimum request-accept to response-valid latency SHALL be 3 cycles, with zero-wait DM handshakes.
REQ-015 A requester SHALL NOT be re-granted in the cycle its response completes; the earliest next grant is the following IDLE cycle.
REQ-016 dm_resp_ready SHALL be 0 outside WAIT, except during stale drain (REQ-023).

Reset
REQ-017 On reset, the FSM SHALL go to IDLE, rr to 0, and the owner register to 0.
REQ-018 During reset, all valid/ready outputs SHALL be 0 and registered bits SHALL be all-zero.
REQ-019 Reset mid-transaction SHALL abandon the transaction without generating a response.

Configuration
REQ-020 With DMI_ARB_TIMEOUT_EN defined, an 8+ bit counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-021 When the counter reaches TIMEOUT_CYCLES without dm_resp_valid, the block SHALL load a response of all-zero data with resp=2'b10 (failed), go to RESP, and set the stale flag.
REQ-022 While the stale flag is set, IDLE SHALL withhold grants.
REQ-023 While the stale flag is set, dm_resp_ready SHALL be 1; one dm response beat SHALL be discarded and clear the flag, or the flag SHALL clear after a further TIMEOUT_CYCLES.
REQ-024 Without DMI_ARB_TIMEOUT_EN, there SHALL be no counter or stale flag, and WAIT SHALL persist indefinitely.

Structure
REQ-025 Package dmi_pkg SHALL hold the width constants, op encodings (NOP 0, READ 1, WRITE 2), resp encodings (OK 0, FAIL 2, BUSY 3) and the FSM state typedef.
REQ-026 The 2-way round-robin grant logic SHALL be sub-module dmi_rr_picker (inputs valid[1:0], rr, advance; output grant[1:0]).

Verification
REQ-027 Requester 0 only, req0_bits={addr 5'h10, data 0, op READ}, DM responds data 34'h1234 OK after 2 cycles -> rsp0_bits={34'h1234, 2'b00}, rsp1_valid never 1.
REQ-028 Both requesters valid continuously after reset -> grants alternate 0,1,0,1; dm_req_bits match each owner's bits.
REQ-029 dm_req_ready held 0 for 10 cycles in ISSUE -> dm_req_bits stable, req0_ready/req1_ready stay 0, no extra dm request.
REQ-030 rsp1_ready held 0 for 5 cycles in RESP -> rsp1_valid and rsp1_bits held; no new grant until handshake.
REQ-031 Timeout enabled, TIMEOUT_CYCLES=8, DM silent -> resp 2'b10 after 8 WAIT cycles; a late DM beat is drained; the next request is then granted.
REQ-032 reset asserted in WAIT -> the next cycle shows IDLE, rr=0, all valids 0, no response to the owner.
